// File: rtl/vga_circle_ctrl_pkg.sv
// Shared raster constants and types for the five-circle lamp display.
package vga_circle_pkg;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam int N_LAMPS = 5;
   localparam int CNT_W   = 11;

   typedef logic [11:0]             rgb444_t;
   typedef logic [N_LAMPS-1:0]      lamp_vec_t;
   typedef logic signed [CNT_W-1:0] cnt_t;

   function automatic logic in_range(input int val, input int lo, input int hi);
      return (val >= lo) && (val <= hi);
   endfunction

endpackage

// File: rtl/vga_circle_ctrl_if.sv
// Bundle between the scan controller and its surroundings (lamp control, hit detector, VGA pins).
interface vga_circle_ctrl_if;
   import vga_circle_pkg::*;

   lamp_vec_t lamp_in;
   lamp_vec_t blink_in;
   lamp_vec_t fc;
   cnt_t      hcnt;
   cnt_t      vcnt;
   logic      hsync;
   logic      vsync;
   rgb444_t   rgb;
   logic      frame_start;

   modport master (
      output lamp_in, blink_in, fc,
      input  hcnt, vcnt, hsync, vsync, rgb, frame_start
   );

   modport slave (
      input  lamp_in, blink_in, fc,
      output hcnt, vcnt, hsync, vsync, rgb, frame_start
   );

endinterface

// File: rtl/vga_circle_ctrl_timing.sv
// Raster generator: pixel-clock divider, h/v counters, raw sync/blanking decode, end-of-frame strobe.
module vga_timing
   import vga_circle_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int H_ACT    = H_ACTIVE,
   parameter int H_FRONT  = H_FP,
   parameter int H_SYNC_W = H_SYNC,
   parameter int H_BACK   = H_BP,
   parameter int V_ACT    = V_ACTIVE,
   parameter int V_FRONT  = V_FP,
   parameter int V_SYNC_W = V_SYNC,
   parameter int V_BACK   = V_BP
) (
   input  logic clk,
   input  logic rst,
   output logic pix_tick_o,
   output cnt_t hcnt_o,
   output cnt_t vcnt_o,
   output logic hsync_raw_o,
   output logic vsync_raw_o,
   output logic video_on_o,
   output logic eof_o
);

   localparam int H_TOT    = H_ACT + H_FRONT + H_SYNC_W + H_BACK;
   localparam int V_TOT    = V_ACT + V_FRONT + V_SYNC_W + V_BACK;
   localparam int HS_FIRST = H_ACT + H_FRONT;
   localparam int HS_LAST  = HS_FIRST + H_SYNC_W - 1;
   localparam int VS_FIRST = V_ACT + V_FRONT;
   localparam int VS_LAST  = VS_FIRST + V_SYNC_W - 1;
   localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_q, div_d;
   cnt_t             hcnt_q, hcnt_d;
   cnt_t             vcnt_q, vcnt_d;
   logic             pix_tick, h_last, v_last;

   // With CLK_DIV=1 the divider is a single bit stuck at 0, so pix_tick is constant 1.
   assign pix_tick = (div_q == DIV_LAST);
   assign h_last   = (hcnt_q == cnt_t'(H_TOT - 1));
   assign v_last   = (vcnt_q == cnt_t'(V_TOT - 1));

   always_comb begin
      // NOTE: every _d gets a default before any branch, so no path can infer a latch.
      div_d  = pix_tick ? '0 : div_q + 1'b1;
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (pix_tick) begin
         if (h_last) begin
            hcnt_d = '0;
            vcnt_d = v_last ? '0 : vcnt_q + cnt_t'(1);
         end else begin
            hcnt_d = hcnt_q + cnt_t'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
      if (rst) begin
         div_q  <= '0;
         hcnt_q <= '0;
         vcnt_q <= '0;
      end else begin
         div_q  <= div_d;
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
      end
   end

   assign pix_tick_o  = pix_tick;
   assign hcnt_o      = hcnt_q;
   assign vcnt_o      = vcnt_q;
   assign hsync_raw_o = !in_range(int'(hcnt_q), HS_FIRST, HS_LAST);
   assign vsync_raw_o = !in_range(int'(vcnt_q), VS_FIRST, VS_LAST);
   assign video_on_o  = (hcnt_q < cnt_t'(H_ACT)) && (vcnt_q < cnt_t'(V_ACT));
   assign eof_o       = pix_tick && h_last && v_last;

endmodule

// File: rtl/vga_circle_ctrl.sv
// Scan controller and colour scheduler for the five-circle lamp display.
// Lamp/blink state is latched once per frame so a frame never mixes two lamp states.
module vga_circle_ctrl
   import vga_circle_pkg::*;
#(
   parameter int      CLK_DIV      = 4,
   parameter int      BLINK_FRAMES = 30,
   parameter rgb444_t COL_ON       = 12'hF00,
   parameter rgb444_t COL_OFF      = 12'h333,
   parameter rgb444_t COL_BG       = 12'h00F,
   parameter int      H_ACT        = H_ACTIVE,
   parameter int      H_FRONT      = H_FP,
   parameter int      H_SYNC_W     = H_SYNC,
   parameter int      H_BACK       = H_BP,
   parameter int      V_ACT        = V_ACTIVE,
   parameter int      V_FRONT      = V_FP,
   parameter int      V_SYNC_W     = V_SYNC,
   parameter int      V_BACK       = V_BP
) (
   input logic              clk,
   input logic              rst,
   vga_circle_ctrl_if.slave vga_if
);

   logic       pix_tick, hsync_raw, vsync_raw, video_on, eof;
   cnt_t       hcnt, vcnt;
   lamp_vec_t  lamp_q, blink_q, lit;
   logic       phase_q, phase_d;
   logic [7:0] frame_cnt_q, frame_cnt_d;
   logic       hsync_q, vsync_q, frame_start_q;
   rgb444_t    rgb_q, rgb_d;

   vga_timing #(
      .CLK_DIV (CLK_DIV),
      .H_ACT   (H_ACT),
      .H_FRONT (H_FRONT),
      .H_SYNC_W(H_SYNC_W),
      .H_BACK  (H_BACK),
      .V_ACT   (V_ACT),
      .V_FRONT (V_FRONT),
      .V_SYNC_W(V_SYNC_W),
      .V_BACK  (V_BACK)
   ) u_timing (
      .clk        (clk),
      .rst        (rst),
      .pix_tick_o (pix_tick),
      .hcnt_o     (hcnt),
      .vcnt_o     (vcnt),
      .hsync_raw_o(hsync_raw),
      .vsync_raw_o(vsync_raw),
      .video_on_o (video_on),
      .eof_o      (eof)
   );

   // A blinking lamp is only shown lit during the "on" half of the blink period.
   assign lit = lamp_q & (~blink_q | {N_LAMPS{phase_q}});

   always_comb begin
      rgb_d = '0;
      if (video_on) begin
         rgb_d = COL_BG;
         // Walk from the highest index down so the lowest hit circle has the last word.
         for (int i = N_LAMPS - 1; i >= 0; i--) begin
            if (vga_if.fc[i]) rgb_d = lit[i] ? COL_ON : COL_OFF;
         end
      end
   end

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      phase_d     = phase_q;
      if (eof) begin
         if (frame_cnt_q == 8'(BLINK_FRAMES - 1)) begin
            frame_cnt_d = '0;
            phase_d     = ~phase_q;
         end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         rgb_q         <= '0;
         frame_start_q <= 1'b0;
         lamp_q        <= '0;
         blink_q       <= '0;
         phase_q       <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         frame_start_q <= eof;
         frame_cnt_q   <= frame_cnt_d;
         phase_q       <= phase_d;
         if (pix_tick) begin
            hsync_q <= hsync_raw;
            vsync_q <= vsync_raw;
            rgb_q   <= rgb_d;
         end
         if (eof) begin
            lamp_q  <= vga_if.lamp_in;
            blink_q <= vga_if.blink_in;
         end
      end
   end

   assign vga_if.hcnt        = hcnt;
   assign vga_if.vcnt        = vcnt;
   assign vga_if.hsync       = hsync_q;
   assign vga_if.vsync       = vsync_q;
   assign vga_if.rgb         = rgb_q;
   assign vga_if.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_circle_ctrl.sv
// Scoreboard bench for vga_circle_ctrl on a shrunken raster so several frames fit in a short run.
module tb_vga_circle_ctrl;
   import vga_circle_pkg::*;

   localparam int CD = 4;
   localparam int BF = 2;
   localparam int HA = 32, HF = 4, HS = 8, HB = 4;
   localparam int VA = 24, VF = 2, VS = 2, VB = 4;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FRAME_CLKS = HT * VT * CD;
   localparam int RAD = 5;
   localparam rgb444_t C_ON = 12'hF00, C_OFF = 12'h333, C_BG = 12'h00F;

   typedef struct packed {
      cnt_t    h;
      cnt_t    v;
      logic    hs;
      logic    vs;
      rgb444_t rgb;
      logic    fs;
   } out_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   lamp_vec_t lamp_drv, blink_drv, fc_drv;
   int cx [N_LAMPS];
   int cy [N_LAMPS];

   int n_checks = 0, n_err = 0;
   int unsigned n_clk = 0, n_push = 0, n_pop = 0, n_eof_exp = 0, n_fs_seen = 0;
   bit in_rst = 1'b1;
   out_t sb[$];
   lamp_vec_t lamp_hist[$], blink_hist[$];

   vga_circle_ctrl_if bus();

   vga_circle_ctrl #(
      .CLK_DIV(CD), .BLINK_FRAMES(BF),
      .COL_ON(C_ON), .COL_OFF(C_OFF), .COL_BG(C_BG),
      .H_ACT(HA), .H_FRONT(HF), .H_SYNC_W(HS), .H_BACK(HB),
      .V_ACT(VA), .V_FRONT(VF), .V_SYNC_W(VS), .V_BACK(VB)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .vga_if(bus)
   );

   always #5 clk = ~clk;

   // Hit detector stand-in: discs of radius RAD around the chosen centres.
   always_comb begin
      fc_drv = '0;
      for (int i = 0; i < N_LAMPS; i++) begin
         if ((int'(bus.hcnt) - cx[i]) ** 2 + (int'(bus.vcnt) - cy[i]) ** 2 <= RAD * RAD)
            fc_drv[i] = 1'b1;
      end
   end
   assign bus.fc       = fc_drv;
   assign bus.lamp_in  = lamp_drv;
   assign bus.blink_in = blink_drv;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic lamp_vec_t hits_at(input int h, input int v);
      lamp_vec_t r = '0;
      for (int i = 0; i < N_LAMPS; i++)
         r[i] = ((h - cx[i]) * (h - cx[i]) + (v - cy[i]) * (v - cy[i])) <= RAD * RAD;
      return r;
   endfunction

   // Colour of a visible pixel in frame f: lamps are those captured at the end of frame f-1,
   // blink phase flips every BF frames counted from reset.
   function automatic rgb444_t pixel_colour(input lamp_vec_t hit, input int f);
      lamp_vec_t lamps  = (f == 0) ? '0 : lamp_hist[f-1];
      lamp_vec_t blinks = (f == 0) ? '0 : blink_hist[f-1];
      bit        on_phase = ((f / BF) % 2) == 1;
      for (int i = 0; i < N_LAMPS; i++) begin
         if (hit[i]) return (lamps[i] && (!blinks[i] || on_phase)) ? C_ON : C_OFF;
      end
      return C_BG;
   endfunction

   // Reference model: pixel p is the p-th pixel tick since reset release.
   initial forever begin
      @(posedge clk);
      if (rst) begin
         in_rst = 1'b1;
         n_clk  = 0;
         sb.delete();
         lamp_hist.delete();
         blink_hist.delete();
      end else begin
         in_rst = 1'b0;
         if (n_clk % CD == CD - 1) begin
            int p, h, v, f;
            out_t e;
            p = int'(n_clk / CD);
            h = p % HT;
            v = (p / HT) % VT;
            f = p / (HT * VT);
            e.h   = cnt_t'((p + 1) % HT);
            e.v   = cnt_t'(((p + 1) / HT) % VT);
            e.hs  = !(h >= HA + HF && h < HA + HF + HS);
            e.vs  = !(v >= VA + VF && v < VA + VF + VS);
            e.fs  = (h == HT - 1) && (v == VT - 1);
            e.rgb = (h < HA && v < VA) ? pixel_colour(hits_at(h, v), f) : 12'h000;
            sb.push_back(e);
            n_push++;
            if (e.fs) begin
               lamp_hist.push_back(lamp_drv);
               blink_hist.push_back(blink_drv);
               n_eof_exp++;
            end
         end
         n_clk++;
      end
   end

   // Monitor: every change of hcnt is a new pixel presented by the DUT.
   initial begin
      cnt_t last_h = '0;
      forever begin
         @(negedge clk);
         if (bus.frame_start) n_fs_seen++;
         if (!in_rst) begin
            if (bus.hcnt != last_h) begin
               if (sb.size() == 0) begin
                  check("sb_underflow", 1, 0);
               end else begin
                  out_t e, a;
                  e = sb.pop_front();
                  n_pop++;
                  a = '{bus.hcnt, bus.vcnt, bus.hsync, bus.vsync, bus.rgb, bus.frame_start};
                  check($sformatf("pixel{h,v,hs,vs,rgb,fs}@%0d", n_pop), longint'(a), longint'(e));
               end
            end else begin
               check("frame_start_width", longint'(bus.frame_start), 0);
            end
         end
         last_h = bus.hcnt;
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_hcnt"},  longint'(bus.hcnt), 0);
      check({tag, "_vcnt"},  longint'(bus.vcnt), 0);
      check({tag, "_hsync"}, longint'(bus.hsync), 1);
      check({tag, "_vsync"}, longint'(bus.vsync), 1);
      check({tag, "_rgb"},   longint'(bus.rgb), 0);
      check({tag, "_fs"},    longint'(bus.frame_start), 0);
   endtask

   // Random lamp/blink changes mid-frame, plus a forced change on every end-of-frame tick.
   task automatic run_clocks(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if ((n_clk % CD == CD - 1) && ((n_clk / CD) % (HT * VT) == HT * VT - 1)) begin
            lamp_drv  = lamp_vec_t'($urandom);
            blink_drv = lamp_vec_t'($urandom);
         end else if ($urandom_range(599, 0) == 0) begin
            lamp_drv  = lamp_vec_t'($urandom);
            blink_drv = lamp_vec_t'($urandom);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < N_LAMPS; i++) begin
         cx[i] = int'($urandom_range(HA - 5, 4));
         cy[i] = int'($urandom_range(VA - 5, 4));
      end
      cx[1] = cx[0] + 2;
      cy[1] = cy[0] + 1;
      lamp_drv  = '0;
      blink_drv = '0;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      repeat (3) @(negedge clk);
      check("hcnt_before_first_tick", longint'(bus.hcnt), 0);
      @(negedge clk);
      check("hcnt_first_tick", longint'(bus.hcnt), 1);

      run_clocks(5 * FRAME_CLKS + FRAME_CLKS / 2);

      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("midreset");
      rst = 1'b0;

      run_clocks(4 * FRAME_CLKS + 8);
      #1;
      check("sb_drain", longint'(sb.size()), 0);
      check("pixel_count", longint'(n_pop), longint'(n_push));
      check("frame_start_count", longint'(n_fs_seen), longint'(n_eof_exp));
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
